datamem_responder: RTL and testbench

//  Data-memory responder: the memory end of the processor's load/store path.
//  - Accepts load/store requests over a valid/ready handshake.
//  - Commits each store, or captures each load's data, in the acceptance cycle.
//  - Returns one in-order response per request after a fixed pipeline latency.
//  - Buffers responses in a FIFO so the processor may stall its consumer side.

---
 rtl/datamem_responder.sv | 119 +++++++++++
 tb/tb_datamem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/datamem_responder.sv
// Data-memory responder: single-ported word memory behind a valid/ready request port,
// fixed-latency response pipeline and an in-order response FIFO.
module datamem_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_WORDS  = 65536,
    parameter int LATENCY    = 2,
    parameter int RSPQ_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          rsp_write,
    output logic                          rsp_err,
    output logic [$clog2(RSPQ_DEPTH):0]   pending
);

    localparam int PTR_W = $clog2(RSPQ_DEPTH);
    localparam int PW    = PTR_W + 1;
    localparam int MAW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [PW-1:0]   DEPTH_P = PW'(RSPQ_DEPTH);

    typedef struct packed {
        logic              write;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic              accept;
    logic              pop;
    logic              in_range;
    logic [MAW-1:0]    mem_idx;
    rsp_t              acc_rsp;

    logic [LATENCY:1]  vld_pipe;
    rsp_t              stage_q [1:LATENCY];

    rsp_t              fifo [RSPQ_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              fifo_empty;
    rsp_t              head;

    // Ready is forced low while reset is asserted; no bypass from a same-cycle pop.
    assign req_ready = reset && (pending < DEPTH_P);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    assign in_range  = {1'b0, req_addr} < MEM_LIM;
    assign mem_idx   = req_addr[MAW-1:0];

    // Loads read the array in the acceptance cycle, so any store from an earlier edge is visible.
    always_comb begin
        acc_rsp       = '0;
        acc_rsp.write = req_write;
        acc_rsp.err   = ~in_range;
        if (!req_write && in_range)
            acc_rsp.data = mem[mem_idx];
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && req_write && in_range)
            mem[mem_idx] <= req_data;
    end

    always_ff @(posedge clk) begin
        stage_q[1] <= acc_rsp;
        for (int i = 2; i <= LATENCY; i++)
            stage_q[i] <= stage_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (vld_pipe[LATENCY])
            fifo[wr_ptr[PTR_W-1:0]] <= stage_q[LATENCY];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pending  <= '0;
        end else begin
            vld_pipe[1] <= accept;
            for (int i = 2; i <= LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
            if (vld_pipe[LATENCY])
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   pending <= pending + PW'(1);
                2'b01:   pending <= pending - PW'(1);
                default: pending <= pending;
            endcase
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign head       = fifo_empty ? '0 : fifo[rd_ptr[PTR_W-1:0]];

    assign rsp_valid  = ~fifo_empty;
    assign rsp_data   = head.data;
    assign rsp_write  = head.write;
    assign rsp_err    = head.err;

endmodule

// File: tb/tb_datamem_responder.sv
// Directed bench for datamem_responder (MEM_WORDS=1024, LATENCY=2, RSPQ_DEPTH=4).
module tb_datamem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_data;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_write, rsp_err;
    logic [2:0]  pending;

    int checks = 0;
    int passes = 0;

    datamem_responder #(
        .ADDR_W(16), .DATA_W(16), .MEM_WORDS(1024), .LATENCY(2), .RSPQ_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_write(rsp_write), .rsp_err(rsp_err), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One request offered at one edge; inputs set at negedge, cleared 1 after the edge.
    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 0; req_write = 0; req_addr = 0; req_data = 0; rsp_ready = 0;
        #2;
        checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", req_ready); else passes++;
        checks++; if ({rsp_valid, rsp_write, rsp_err, rsp_data} !== 19'h0)
            $display("FAIL reset_rsp got v%b w%b e%b d%h exp all 0", rsp_valid, rsp_write, rsp_err, rsp_data); else passes++;
        checks++; if (pending !== 3'd0) $display("FAIL reset_pending got %0d exp 0", pending); else passes++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL release_ready got %b exp 1", req_ready); else passes++;
    endtask

    task automatic test_store_load();
        bit ok;
        send(1'b1, 16'h0010, 16'h1234);
        checks++; if (pending !== 3'd1 || rsp_valid !== 1'b0)
            $display("FAIL st_edge0 got p%0d v%b exp p1 v0", pending, rsp_valid); else passes++;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL st_edge1 got v%b exp 0", rsp_valid); else passes++;
        @(posedge clk); #1;
        checks++; if ({rsp_valid, rsp_write, rsp_err, rsp_data} !== {1'b1, 1'b1, 1'b0, 16'h0})
            $display("FAIL st_rsp got v%b w%b e%b d%h exp v1 w1 e0 d0000", rsp_valid, rsp_write, rsp_err, rsp_data); else passes++;
        pop_one();
        checks++; if (pending !== 3'd0 || rsp_valid !== 1'b0)
            $display("FAIL st_pop got p%0d v%b exp p0 v0", pending, rsp_valid); else passes++;
        send(1'b0, 16'h0010, 16'hFFFF);
        wait_rsp(ok);
        checks++; if (!ok || {rsp_write, rsp_err, rsp_data} !== {1'b0, 1'b0, 16'h1234})
            $display("FAIL ld_rsp got ok%b w%b e%b d%h exp w0 e0 d1234", ok, rsp_write, rsp_err, rsp_data); else passes++;
        pop_one();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [16:0] exp_rsp [4];
        exp_rsp[0] = {1'b1, 16'h0000};
        exp_rsp[1] = {1'b0, 16'hBEEF};
        exp_rsp[2] = {1'b1, 16'h0000};
        exp_rsp[3] = {1'b0, 16'h0001};
        send(1'b1, 16'h0020, 16'hBEEF);
        send(1'b0, 16'h0020, 16'h0000);
        send(1'b1, 16'h0020, 16'h0001);
        send(1'b0, 16'h0020, 16'h0000);
        checks++; if (pending !== 3'd4) $display("FAIL b2b_pending got %0d exp 4", pending); else passes++;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(ok);
            checks++; if (!ok || {rsp_write, rsp_data} !== exp_rsp[i])
                $display("FAIL b2b_rsp%0d got ok%b w%b d%h exp %h", i, ok, rsp_write, rsp_data, exp_rsp[i]); else passes++;
            pop_one();
        end
    endtask

    task automatic test_full_stall();
        bit ok;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 16'h0030 + 16'(i), 16'hA000 + 16'(i));
            wait_rsp(ok);
            pop_one();
        end
        for (int i = 0; i < 4; i++)
            send(1'b0, 16'h0030 + 16'(i), 16'h0);
        checks++; if (pending !== 3'd4 || req_ready !== 1'b0)
            $display("FAIL full_state got p%0d r%b exp p4 r0", pending, req_ready); else passes++;
        // Fifth load held while full: must not be taken.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0034;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pending !== 3'd4 || req_ready !== 1'b0)
            $display("FAIL full_hold got p%0d r%b exp p4 r0", pending, req_ready); else passes++;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hA000)
            $display("FAIL full_head got v%b d%h exp v1 dA000", rsp_valid, rsp_data); else passes++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (pending !== 3'd3 || req_ready !== 1'b1)
            $display("FAIL pop_no_accept got p%0d r%b exp p3 r1", pending, req_ready); else passes++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (pending !== 3'd4) $display("FAIL late_accept got p%0d exp 4", pending); else passes++;
        for (int i = 1; i < 5; i++) begin
            wait_rsp(ok);
            checks++; if (!ok || rsp_data !== 16'hA000 + 16'(i))
                $display("FAIL full_rsp%0d got ok%b d%h exp %h", i, ok, rsp_data, 16'hA000 + 16'(i)); else passes++;
            pop_one();
        end
    endtask

    task automatic test_out_of_range();
        bit ok;
        send(1'b1, 16'h0100, 16'h5A5A);
        wait_rsp(ok);
        pop_one();
        send(1'b0, 16'h0400, 16'h0);
        wait_rsp(ok);
        checks++; if (!ok || {rsp_write, rsp_err, rsp_data} !== {1'b0, 1'b1, 16'h0})
            $display("FAIL oor_load got ok%b w%b e%b d%h exp w0 e1 d0000", ok, rsp_write, rsp_err, rsp_data); else passes++;
        pop_one();
        send(1'b1, 16'h0500, 16'hFFFF);
        wait_rsp(ok);
        checks++; if (!ok || {rsp_write, rsp_err, rsp_data} !== {1'b1, 1'b1, 16'h0})
            $display("FAIL oor_store got ok%b w%b e%b d%h exp w1 e1 d0000", ok, rsp_write, rsp_err, rsp_data); else passes++;
        pop_one();
        send(1'b0, 16'h0100, 16'h0);
        wait_rsp(ok);
        checks++; if (!ok || {rsp_err, rsp_data} !== {1'b0, 16'h5A5A})
            $display("FAIL oor_alias got ok%b e%b d%h exp e0 d5A5A", ok, rsp_err, rsp_data); else passes++;
        pop_one();
    endtask

    task automatic test_reset_midflight();
        bit ok;
        send(1'b1, 16'h0040, 16'h7777);
        wait_rsp(ok);
        pop_one();
        send(1'b0, 16'h0040, 16'h0);
        send(1'b0, 16'h0041, 16'h0);
        send(1'b0, 16'h0042, 16'h0);
        checks++; if (pending !== 3'd3) $display("FAIL mid_pending got %0d exp 3", pending); else passes++;
        #3;
        reset = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || pending !== 3'd0 || req_ready !== 1'b0)
            $display("FAIL async_clear got v%b p%0d r%b exp v0 p0 r0", rsp_valid, pending, req_ready); else passes++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || pending !== 3'd0)
            $display("FAIL no_stale got v%b p%0d exp v0 p0", rsp_valid, pending); else passes++;
        send(1'b0, 16'h0040, 16'h0);
        wait_rsp(ok);
        checks++; if (!ok || rsp_data !== 16'h7777)
            $display("FAIL mem_persist got ok%b d%h exp 7777", ok, rsp_data); else passes++;
        pop_one();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_full_stall();
        test_out_of_range();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
